mem_access_unit: RTL and testbench

- Memory-stage load/store bridge between the MIPS pipeline and the data-memory bus.
- Store path: narrows 32-bit register data into byte/half/word lanes with byte enables.
- Load path: receives the word from the bus, selects the addressed lane, then sign- or zero-extends it to 32 bits.
- Sequences each access with a req/ack handshake, stalls the pipeline while waiting, and flags misalignment and bus timeout.

---
 rtl/mem_pkg.sv | 26 ++
 rtl/mem_rdata_ext.sv | 36 +++
 rtl/mem_access_unit.sv | 142 ++++++++++++++
 tb/tb_mem_access_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory access unit.
//   - Size encodings for byte, half and word requests.
//   - State encoding for the access sequencer.
//   - aligned(): reports whether an address is legal for a given access size.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_DONE = 2'b10
  } state_t;

  // The reserved size encoding is handled as a word access.
  function automatic logic aligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: aligned = 1'b1;
      SZ_HALF: aligned = ~addr_lo[0];
      default: aligned = (addr_lo == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_rdata_ext.sv
// Load-path lane select and extension.
// Ports:
//   word    - 32-bit word returned by the bus
//   addr_lo - low address bits selecting the byte/half lane
//   size    - access size (byte, half, word/reserved)
//   zext    - 1 = zero-extend, 0 = sign-extend (ignored for words)
//   result  - extended 32-bit load value
module mem_rdata_ext
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        zext,
  output logic [31:0] result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_lane = word[7:0];
      2'd1:    byte_lane = word[15:8];
      2'd2:    byte_lane = word[23:16];
      default: byte_lane = word[31:24];
    endcase
    half_lane = addr_lo[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: result = {{24{byte_lane[7] & ~zext}}, byte_lane};
      SZ_HALF: result = {{16{half_lane[15] & ~zext}}, half_lane};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store bridge between the pipeline and the data-memory bus.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   req_*                 - load/store request from the MEM stage
//   stall                 - holds the pipeline while an access is accepted or pending
//   rdata_valid, rdata    - one-cycle load result pulse and extended data
//   exc_adel, exc_ades    - misaligned load/store pulses (combinational)
//   bus_err               - one-cycle pulse when the bus never acknowledged
//   bus_req..bus_wdata    - registered bus request fields, held until ack
//   bus_ack, bus_rdata    - bus completion and read word
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = $clog2(TIMEOUT)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        rdata_valid,
  output logic [31:0] rdata,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             we_q;
  logic [1:0]       size_q;
  logic             uns_q;
  logic [1:0]       lo_q;

  logic        req_aligned;
  logic        in_idle;
  logic        accept;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] ext_word;

  assign req_aligned = aligned(req_size, req_addr[1:0]);
  assign in_idle     = (state_q == S_IDLE);
  assign accept      = in_idle & req_valid & req_aligned;
  assign stall       = accept | (state_q == S_WAIT);
  assign exc_adel    = in_idle & req_valid & ~req_aligned & ~req_we;
  assign exc_ades    = in_idle & req_valid & ~req_aligned & req_we;
  // Derived from the state register, so it is registered and drops with reset.
  assign bus_req     = (state_q == S_WAIT);

  always_comb begin
    case (req_size)
      SZ_BYTE: begin
        be_d    = 4'b0001 << req_addr[1:0];
        wdata_d = {4{req_wdata[7:0]}};
      end
      SZ_HALF: begin
        be_d    = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{req_wdata[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = req_wdata;
      end
    endcase
  end

  mem_rdata_ext u_rdata_ext (
    .word    (bus_rdata),
    .addr_lo (lo_q),
    .size    (size_q),
    .zext    (uns_q),
    .result  (ext_word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      lo_q        <= 2'b00;
      rdata_valid <= 1'b0;
      rdata       <= '0;
      bus_err     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_be      <= '0;
      bus_wdata   <= '0;
    end else begin
      rdata_valid <= 1'b0;
      bus_err     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_q   <= S_WAIT;
            cnt_q     <= '0;
            we_q      <= req_we;
            size_q    <= req_size;
            uns_q     <= req_unsigned;
            lo_q      <= req_addr[1:0];
            bus_we    <= req_we;
            bus_addr  <= {req_addr[31:2], 2'b00};
            bus_be    <= be_d;
            bus_wdata <= req_we ? wdata_d : 32'h0;
          end
        end
        S_WAIT: begin
          // Ack is checked first so it wins over a coincident timeout.
          if (bus_ack) begin
            state_q <= S_DONE;
            if (!we_q) begin
              rdata       <= ext_word;
              rdata_valid <= 1'b1;
            end
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_q <= S_DONE;
            bus_err <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        stall, rdata_valid, exc_adel, exc_ades, bus_err;
  logic [31:0] rdata;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  int checks = 0;
  int errors = 0;

  typedef enum int {EV_BUS, EV_RDATA, EV_ERR, EV_ADEL, EV_ADES} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [68:0] data;
  } ev_t;
  ev_t sb[$];

  mem_access_unit #(.TIMEOUT(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .stall        (stall),
    .rdata_valid  (rdata_valid),
    .rdata        (rdata),
    .exc_adel     (exc_adel),
    .exc_ades     (exc_ades),
    .bus_err      (bus_err),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_be       (bus_be),
    .bus_wdata    (bus_wdata),
    .bus_ack      (bus_ack),
    .bus_rdata    (bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input ev_kind_t k, input logic [68:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic expect_ev(input ev_kind_t k, input logic [68:0] act);
    ev_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d with no expected event", int'(k));
    end else begin
      e = sb.pop_front();
      check("event_kind", 69'(int'(k)), 69'(int'(e.kind)));
      if (k == e.kind && (k == EV_BUS || k == EV_RDATA)) check("event_data", act, e.data);
    end
  endtask

  // Monitor: compares every DUT-presented event against the scoreboard.
  logic req_prev = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      if (bus_req && !req_prev) expect_ev(EV_BUS, {bus_we, bus_be, bus_addr, bus_wdata});
      if (rdata_valid)          expect_ev(EV_RDATA, {37'h0, rdata});
      if (bus_err)              expect_ev(EV_ERR, '0);
      if (exc_adel)             expect_ev(EV_ADEL, '0);
      if (exc_ades)             expect_ev(EV_ADES, '0);
    end
    req_prev = bus_req;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one aligned request for a single cycle; returns at the start of the first WAIT cycle.
  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    @(negedge clk);
    check("stall_on_accept", 69'(stall), 69'(1));
    step();
    req_valid = 1'b0;
  endtask

  // Acks after 'delay' WAIT cycles, then checks the DONE cycle.
  task automatic respond(input int delay, input logic [31:0] rd, input logic exp_rv);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check("bus_req_wait", 69'(bus_req), 69'(1));
      step();
    end
    bus_ack = 1'b1; bus_rdata = rd;
    @(negedge clk);
    check("bus_req_at_ack", 69'(bus_req), 69'(1));
    step();
    bus_ack = 1'b0; bus_rdata = 32'h0;
    @(negedge clk);
    check("done_rdata_valid", 69'(rdata_valid), 69'(exp_rv));
    check("done_stall_req_err", 69'({stall, bus_req, bus_err}), 69'(0));
    step();
  endtask

  task automatic do_load(input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                         input logic [31:0] rd, input logic [3:0] be, input logic [31:0] exp);
    push(EV_BUS, {1'b0, be, addr & 32'hFFFF_FFFC, 32'h0});
    push(EV_RDATA, {37'h0, exp});
    issue(1'b0, sz, uns, addr, 32'h0);
    respond(0, rd, 1'b1);
  endtask

  task automatic do_store(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] be, input logic [31:0] exp_wd);
    push(EV_BUS, {1'b1, be, addr & 32'hFFFF_FFFC, exp_wd});
    issue(1'b1, sz, 1'b0, addr, wd);
    respond(0, 32'h0, 1'b0);
  endtask

  task automatic do_misaligned(input logic we, input logic [1:0] sz, input logic [31:0] addr);
    push(we ? EV_ADES : EV_ADEL, '0);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = 1'b0;
    req_addr = addr; req_wdata = 32'h1234_5678;
    @(negedge clk);
    check("misaligned_stall", 69'(stall), 69'(0));
    step();
    req_valid = 1'b0;
    @(negedge clk);
    check("misaligned_no_req", 69'(bus_req), 69'(0));
    step();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic seen;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
    #12;
    check("reset_ctrl", 69'({stall, rdata_valid, exc_adel, exc_ades, bus_err, bus_req, bus_we}),
          69'(0));
    check("reset_bus", {1'b0, bus_be, bus_addr, bus_wdata}, '0);
    check("reset_rdata", 69'(rdata), 69'(0));
    reset = 1'b0;
    step();

    // Loads
    do_load(SZ_BYTE, 1'b0, 32'h0000_1003, 32'h80FF_1234, 4'b1000, 32'hFFFF_FF80);
    do_load(SZ_HALF, 1'b1, 32'h0000_1002, 32'h9ABC_5678, 4'b1100, 32'h0000_9ABC);
    do_load(SZ_HALF, 1'b0, 32'h0000_1002, 32'h9ABC_5678, 4'b1100, 32'hFFFF_9ABC);
    do_load(SZ_BYTE, 1'b1, 32'h0000_1001, 32'h0000_8000, 4'b0010, 32'h0000_0080);
    do_load(SZ_BYTE, 1'b0, 32'h0000_1000, 32'h1234_567F, 4'b0001, 32'h0000_007F);
    do_load(SZ_HALF, 1'b0, 32'h0000_1000, 32'hFFFF_7FFE, 4'b0011, 32'h0000_7FFE);
    do_load(SZ_WORD, 1'b0, 32'h0000_1004, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
    do_load(2'b11,   1'b1, 32'h0000_1008, 32'h8765_4321, 4'b1111, 32'h8765_4321);

    // Stores
    do_store(SZ_BYTE, 32'h0000_2001, 32'h1234_56AB, 4'b0010, 32'hABAB_ABAB);
    do_store(SZ_HALF, 32'h0000_2002, 32'h0000_BEEF, 4'b1100, 32'hBEEF_BEEF);
    do_store(SZ_WORD, 32'h0000_2004, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);

    // Misaligned
    do_misaligned(1'b1, SZ_WORD, 32'h0000_2002);
    do_misaligned(1'b0, SZ_HALF, 32'h0000_1001);
    do_misaligned(1'b0, SZ_WORD, 32'h0000_1002);
    do_misaligned(1'b1, SZ_HALF, 32'h0000_2003);

    // Timeout: bus_req high for TIMEOUT cycles, then a bus_err pulse
    push(EV_BUS, {1'b0, 4'b1111, 32'h0000_3000, 32'h0});
    push(EV_ERR, '0);
    issue(1'b0, SZ_WORD, 1'b0, 32'h0000_3000, 32'h0);
    cnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus_req) cnt++;
      if (bus_err) begin
        seen = 1'b1;
        check("timeout_no_rdata_valid", 69'(rdata_valid), 69'(0));
      end
      step();
    end
    check("timeout_err_seen", 69'(seen), 69'(1));
    check("timeout_req_cycles", 69'(cnt), 69'(16));

    // Ack on the final WAIT cycle wins over the timeout
    push(EV_BUS, {1'b0, 4'b1111, 32'h0000_3000, 32'h0});
    push(EV_RDATA, {37'h0, 32'h1122_3344});
    issue(1'b0, SZ_WORD, 1'b0, 32'h0000_3000, 32'h0);
    respond(15, 32'h1122_3344, 1'b1);

    // Reset while waiting drops bus_req and stall immediately
    push(EV_BUS, {1'b0, 4'b1111, 32'h0000_4000, 32'h0});
    issue(1'b0, SZ_WORD, 1'b0, 32'h0000_4000, 32'h0);
    step();
    #2;
    check("wait_before_reset", 69'({bus_req, stall}), 69'(2'b11));
    reset = 1'b1;
    #1;
    check("async_reset_drop", 69'({bus_req, stall}), 69'(0));
    step();
    check("reset_no_pulses", 69'({rdata_valid, bus_err}), 69'(0));
    reset = 1'b0;
    step();
    do_load(SZ_WORD, 1'b0, 32'h0000_4000, 32'h55AA_55AA, 4'b1111, 32'h55AA_55AA);

    repeat (3) step();
    check("scoreboard_drained", 69'(sb.size()), 69'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
